// File: rtl/ham_dec_arbiter.sv
// Two-requester round-robin front end sharing one Hamming(15,11) decoder,
// with a registered back-pressurable result stage and per-requester correction counters.

module ham_15_11_decoder (
  input  logic [14:0] c,
  output logic [10:0] q
);
  logic [3:0]  syn_c;
  logic [14:0] fix_c;

  // Bit k of the syndrome covers the positions whose index has bit k set.
  always_comb begin
    syn_c = {^(c & 15'h7F80), ^(c & 15'h7878), ^(c & 15'h6666), ^(c & 15'h5555)};
    fix_c = c;
    if (syn_c != 4'd0) fix_c = c ^ (15'd1 << (syn_c - 4'd1));
    q = {fix_c[14:8], fix_c[6:4], fix_c[2]};
  end
endmodule

module ham_dec_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [14:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [14:0]      req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_src,
  output logic             out_corr,
  output logic [3:0]       out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt0,
  output logic [CNT_W-1:0] corr_cnt1
);
  localparam logic [0:0]  ST_EMPTY = 1'b0;
  localparam logic [0:0]  ST_FULL  = 1'b1;
  localparam logic [14:0] SYN_M0   = 15'h5555;
  localparam logic [14:0] SYN_M1   = 15'h6666;
  localparam logic [14:0] SYN_M2   = 15'h7878;
  localparam logic [14:0] SYN_M3   = 15'h7F80;

  logic [0:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [10:0]      out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             out_corr_q, out_corr_d;
  logic [3:0]       out_syn_q, out_syn_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             cap_c, gnt_vld_c, gnt_idx_c;
  logic [14:0]      sel_cw_c;
  logic [3:0]       syn_c;
  logic [10:0]      dec_q_c;

  // Round-robin grant; only offered when the result register can take a word.
  always_comb begin
    cap_c     = (state_q == ST_EMPTY) | out_ready;
    gnt_vld_c = 1'b0;
    gnt_idx_c = 1'b0;
    if (rst_n && cap_c) begin
      if (req0_valid && req1_valid) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld_c = 1'b1;
      end else if (req1_valid) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld_c & ~gnt_idx_c;
  assign req1_ready = gnt_vld_c & gnt_idx_c;

  // Decoder and syndrome both look at the same selected codeword.
  assign sel_cw_c = gnt_idx_c ? req1_data : req0_data;
  assign syn_c    = {^(sel_cw_c & SYN_M3), ^(sel_cw_c & SYN_M2),
                     ^(sel_cw_c & SYN_M1), ^(sel_cw_c & SYN_M0)};

  ham_15_11_decoder u_dec (
    .c (sel_cw_c),
    .q (dec_q_c)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_corr_d   = out_corr_q;
    out_syn_d    = out_syn_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (gnt_vld_c) begin
      state_d      = ST_FULL;
      last_grant_d = gnt_idx_c;
      out_data_d   = dec_q_c;
      out_src_d    = gnt_idx_c;
      out_corr_d   = |syn_c;
      out_syn_d    = syn_c;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end

    // Saturating counters; a clear overrides a coincident increment.
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (gnt_vld_c && (syn_c != 4'd0)) begin
      if (!gnt_idx_c && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
      if (gnt_idx_c && (cnt1_q != {CNT_W{1'b1}}))  cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      out_corr_q   <= 1'b0;
      out_syn_q    <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_corr_q   <= out_corr_d;
      out_syn_q    <= out_syn_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_corr  = out_corr_q;
  assign out_syn   = out_syn_q;
  assign corr_cnt0 = cnt0_q;
  assign corr_cnt1 = cnt1_q;
endmodule
